// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end and the decode-stage register.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instruction;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the two low bits are forced to zero.
    function automatic logic [FETCH_XLEN-1:0] word_align(input logic [FETCH_XLEN-1:0] addr);
        return {addr[FETCH_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and occupancy count.
// Only pointers and count are reset; the storage array holds data only.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A write into a full queue is only legal when the head leaves the same cycle.
    assign do_push = push & ~flush & (~full | do_pop);

    // Storage write; no reset on the data array.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and count update; a flush empties the queue in one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch front end: issues sequential ROM requests,
// tolerates ROM wait states, queues (pc, instruction) pairs for decode and
// flushes/refetches on a redirect from execute.
// XLEN must match fetch_pkg::FETCH_XLEN, since the queue stores fetch_entry_t.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic [XLEN-1:0]            rom_address,
    output logic                       rom_enable,
    input  logic [XLEN-1:0]            rom_data,
    input  logic                       rom_wait,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instruction,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  inflight_pc;
    logic [XLEN-1:0]  redirect_target;
    logic             inflight;
    logic             drop;
    logic             req_accept;
    logic             resp;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit_used;
    logic [CNT_W-1:0] count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign redirect_target = word_align(redirect_pc);
    assign rom_address     = redirect_valid ? redirect_target : fetch_pc;

    // Credit rule: a slot is reserved for every request in flight, so a
    // response can always be written without overflowing the queue.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign rom_enable  = redirect_valid | (credit_used < (CNT_W+1)'(DEPTH));

    assign req_accept = rom_enable & ~rom_wait;
    assign resp       = inflight & ~rom_wait;
    // A response in a redirect cycle, or one marked stale, belongs to the old stream.
    assign push       = resp & ~drop & ~redirect_valid;

    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    assign push_entry = '{pc: inflight_pc, instruction: rom_data};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    // The storage array is not reset, so the head is masked to zero while
    // the queue is empty; while valid it is the registered head entry.
    assign out_pc          = out_valid ? head.pc : '0;
    assign out_instruction = out_valid ? head.instruction : '0;
    assign occupancy       = count;

    // Request, in-flight and stale-response tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (req_accept) begin
                fetch_pc    <= rom_address + XLEN'(4);
                inflight_pc <= rom_address;
            end else if (redirect_valid) begin
                fetch_pc    <= redirect_target;
            end

            if (req_accept) begin
                inflight <= 1'b1;
            end else if (resp) begin
                inflight <= 1'b0;
            end

            // A redirect while the ROM is still holding an old request marks
            // that response stale; it is discarded when it finally arrives.
            if (redirect_valid && inflight && rom_wait) begin
                drop <= 1'b1;
            end else if (resp) begin
                drop <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined RV32 core, replacing the single-register IF stage with a prefetch queue of DEPTH entries. It issues sequential requests to the buffered instruction ROM, absorbs `rom_wait` stalls, and delivers (pc, instruction) pairs to decode over a valid/ready handshake. A redirect from execute flushes the queue, discards in-flight responses and restarts fetch at the new target.

## Interface
- `XLEN`, 32: address/instruction width.
- `DEPTH`, 4: queue entries, power of two, ≥ 2.
- `RESET_PC`, 0: first fetch address after reset.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rom_address` out XLEN: request address.
- `rom_enable` out 1: request strobe.
- `rom_data` in XLEN: response data.
- `rom_wait` in 1: ROM stall; no acceptance and no response this cycle.
- `redirect_valid` in 1: branch/jump taken, flush and refetch.
- `redirect_pc` in XLEN: target; bits [1:0] ignored and treated as 0.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: decode accepts head.
- `out_pc` out XLEN: head PC.
- `out_instruction` out XLEN: head instruction.
- `occupancy` out $clog2(DEPTH+1): entries held.

## Operation
- ROM protocol: a request is accepted at an edge where `rom_enable`=1 and `rom_wait`=0. Its data is on `rom_data` in the first later cycle with `rom_wait`=0. At most one request is in flight. A response cycle may also accept a new request, giving 1 instruction/cycle.
- State: `fetch_pc`, `inflight`, `inflight_pc`, `drop`, plus the queue.
- Combinational outputs:
  - `rom_address` = `redirect_valid` ? `redirect_pc` : `fetch_pc`.
  - `rom_enable` = `redirect_valid` | (`occupancy` + `inflight` < DEPTH).
- On an accepted request: `inflight_pc` ← `rom_address`, `fetch_pc` ← `rom_address`+4 (mod 2^XLEN, wraps at top of address space), `inflight` ← 1.
- Response cycle (`inflight`=1, `rom_wait`=0):
  - push {`inflight_pc`, `rom_data`} unless `drop`=1 or `redirect_valid`=1;
  - clear `drop`;
  - clear `inflight` unless a new request is accepted the same cycle.
- Pop on `out_valid` & `out_ready`. Push and pop in the same cycle leave occupancy unchanged. A push when full cannot occur because the credit rule prevents it; the bench asserts this.
- Redirect cycle:
  - queue emptied at the edge; a same-cycle pop counts as delivered;
  - `fetch_pc` ← `redirect_pc` (+4 if accepted);
  - if `inflight`=1 and `rom_wait`=1, set `drop`=1 so the stale response is discarded;
  - a redirect repeated while `drop`=1 keeps `drop`=1.
- `out_valid`, `out_pc` and `out_instruction` stay stable while `out_valid`=1 and `out_ready`=0. The only exception is a flush.

## Timing
- Reset values (async, immediate):
  - `out_valid`=0, `occupancy`=0, `rom_enable`=1, `rom_address`=RESET_PC;
  - `fetch_pc`=RESET_PC, `inflight`=0, `drop`=0;
  - `out_pc`/`out_instruction`=0.
- Reset asserted mid-operation discards the queue and in-flight state. Any ROM response arriving after release without a new request is ignored, because `inflight`=0.
- Latency: request accepted at edge N → response in cycle N+1 (no wait) → written at edge N+1 → `out_valid` in cycle N+2.
- Redirect in cycle N with `rom_wait`=0 → first new instruction valid in cycle N+2.
- `rom_wait` held k cycles delays the response by k cycles. Queued entries keep draining to decode during the wait.
- Steady state with `out_ready`=1: one instruction per cycle, occupancy ≤ 1.

## Structure
- Package `fetch_pkg`: `fetch_entry_t` struct {pc, instruction}, shared with the decode-stage register.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, DEPTH entries, registered read pointer, flush input, count output. Its reset is async active-low and resets pointers and count only.
- The request/credit/drop logic lives in `fetch_queue`.

## Test plan
- Reset release, `rom_wait`=0, `out_ready`=1:
  - ROM returns `32'h00000013` for every address.
  - Required: `out_pc` = 0, 4, 8, ... on consecutive cycles from cycle 2, with no bubbles.
- `out_ready`=0 for 10 cycles:
  - occupancy saturates at 4 and `rom_enable` drops once occupancy + inflight = 4;
  - head stays at pc 0;
  - releasing ready drains pcs 0, 4, 8, 12, 16 in order.
- Redirect to `32'h00000103` in a cycle with a response returning:
  - response dropped, queue flushed;
  - `rom_address` = `32'h100` that cycle;
  - next `out_pc` = `32'h100` two cycles later.
- Redirect while `rom_wait`=1 with a request in flight:
  - stale response dropped;
  - first delivered pc is the redirect target;
  - no pc from the old stream appears.
- `RESET_PC`=`32'hFFFFFFF8`: pcs FFFFFFF8, FFFFFFFC, 00000000 in sequence.
- `reset_n` pulsed low mid-stream with the queue holding 3 entries:
  - `out_valid` falls immediately, occupancy = 0;
  - fetch restarts at RESET_PC.
